// File: rtl/chacha_ks_arbiter.sv
// -----------------------------------------------------------------------------
// chacha_ks_arbiter
//
// Shares one ChaCha keystream unit among NUM_REQ requesters. Each requester
// presents its own key / nonce / block counter. A round-robin arbiter picks one
// request, loads the winner's context into the unit, pulses cfg_we and then
// ks_req, waits for the 512-bit block, and returns it tagged with the
// requester ID.
//
// Optional feature: define CHACHA_ARB_WDOG_EN to enable a watchdog in S_WAIT.
// After WDOG_CYCLES cycles with no ks_valid, the arbiter returns an error
// response (rsp_err = 1, rsp_data = 0). Without the macro, S_WAIT waits
// indefinitely and rsp_err is tied to 0.
//
// Parameters
//   NUM_REQ      number of requesters (2..8)
//   ID_W         requester ID width, >= clog2(NUM_REQ)
//   WDOG_CYCLES  watchdog limit in S_WAIT (watchdog build only)
//
// Ports
//   clk, rst_n   clock, asynchronous active-low reset
//   req_valid    per-requester request, held until its req_ready bit
//   req_key      per-requester 256-bit key, slice i = [i*256 +: 256]
//   req_nonce    per-requester 96-bit nonce, slice i = [i*96 +: 96]
//   req_ctr      per-requester 32-bit block counter, slice i = [i*32 +: 32]
//   req_ready    one-hot 1-cycle pulse: request accepted, context captured
//   rsp_valid    1-cycle pulse: rsp_id / rsp_data / rsp_err valid
//   rsp_id       requester the response belongs to
//   rsp_data     keystream block, held until the next response
//   rsp_err      watchdog abort flag (rsp_data = 0 when set)
//   ks_cfg_we    to unit cfg_we
//   ks_key       to unit chacha_key
//   ks_nonce     to unit chacha_nonce
//   ks_ctr       to unit chacha_ctr_init
//   ks_req       to unit ks_req
//   ks_valid     from unit, block ready
//   ks_data      from unit, keystream block
//   busy         high in every state except S_IDLE
//   blk_count    successful responses, wraps at 2^32
// -----------------------------------------------------------------------------
module chacha_ks_arbiter #(
  parameter int NUM_REQ     = 4,
  parameter int ID_W        = 2,
  parameter int WDOG_CYCLES = 64
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [NUM_REQ-1:0]     req_valid,
  input  logic [NUM_REQ*256-1:0] req_key,
  input  logic [NUM_REQ*96-1:0]  req_nonce,
  input  logic [NUM_REQ*32-1:0]  req_ctr,
  output logic [NUM_REQ-1:0]     req_ready,
  output logic                   rsp_valid,
  output logic [ID_W-1:0]        rsp_id,
  output logic [511:0]           rsp_data,
  output logic                   rsp_err,
  output logic                   ks_cfg_we,
  output logic [255:0]           ks_key,
  output logic [95:0]            ks_nonce,
  output logic [31:0]            ks_ctr,
  output logic                   ks_req,
  input  logic                   ks_valid,
  input  logic [511:0]           ks_data,
  output logic                   busy,
  output logic [31:0]            blk_count
);

  // Elaboration-time parameter sanity.
  if (NUM_REQ < 2 || NUM_REQ > 8 || ID_W < $clog2(NUM_REQ) || WDOG_CYCLES < 1) begin : g_bad_param
    $error("chacha_ks_arbiter: illegal parameter combination");
  end

  typedef enum logic [2:0] {
    S_IDLE,
    S_CFG,
    S_REQ,
    S_WAIT,
    S_RESP
  } state_t;

  state_t          state;
  logic [ID_W-1:0] rr_ptr;
  logic [ID_W-1:0] cur_id;

`ifdef CHACHA_ARB_WDOG_EN
  localparam int WD_W = $clog2(WDOG_CYCLES) + 1;
  logic [WD_W-1:0] wdog_cnt;
  logic            err_pend;
`endif

  // Round-robin pick: first set request searching upward from rr_ptr+1,
  // wrapping at NUM_REQ, so the last winner has lowest priority next time.
  logic                 grant_any;
  logic [ID_W-1:0]      grant_id;
  logic [NUM_REQ-1:0]   grant_oh;
  logic [255:0]         sel_key;
  logic [95:0]          sel_nonce;
  logic [31:0]          sel_ctr;
  int                   idx;
  int                   win;

  always_comb begin
    grant_any = 1'b0;
    idx       = 0;
    win       = 0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      idx = (int'(rr_ptr) + k) % NUM_REQ;
      if (!grant_any && req_valid[idx]) begin
        grant_any = 1'b1;
        win       = idx;
      end
    end
    grant_id  = ID_W'(win);
    grant_oh  = NUM_REQ'(1) << win;
    sel_key   = req_key[win*256 +: 256];
    sel_nonce = req_nonce[win*96 +: 96];
    sel_ctr   = req_ctr[win*32 +: 32];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      rr_ptr    <= ID_W'(NUM_REQ - 1);
      cur_id    <= '0;
      req_ready <= '0;
      rsp_valid <= 1'b0;
      rsp_id    <= '0;
      rsp_data  <= '0;
      ks_cfg_we <= 1'b0;
      ks_key    <= '0;
      ks_nonce  <= '0;
      ks_ctr    <= '0;
      ks_req    <= 1'b0;
      busy      <= 1'b0;
      blk_count <= '0;
`ifdef CHACHA_ARB_WDOG_EN
      rsp_err   <= 1'b0;
      wdog_cnt  <= '0;
      err_pend  <= 1'b0;
`endif
    end else begin
      // Pulse outputs default low; each state raises its own for one cycle.
      req_ready <= '0;
      rsp_valid <= 1'b0;
      ks_cfg_we <= 1'b0;
      ks_req    <= 1'b0;
`ifdef CHACHA_ARB_WDOG_EN
      rsp_err   <= 1'b0;
`endif
      case (state)
        S_IDLE: begin
          if (grant_any) begin
            req_ready <= grant_oh;
            ks_key    <= sel_key;
            ks_nonce  <= sel_nonce;
            ks_ctr    <= sel_ctr;
            cur_id    <= grant_id;
            rr_ptr    <= grant_id;
            ks_cfg_we <= 1'b1;
            busy      <= 1'b1;
            state     <= S_CFG;
          end
        end
        S_CFG: begin
          ks_req <= 1'b1;
          state  <= S_REQ;
        end
        S_REQ: begin
`ifdef CHACHA_ARB_WDOG_EN
          wdog_cnt <= '0;
`endif
          state <= S_WAIT;
        end
        S_WAIT: begin
          // ks_valid wins over a watchdog expiry in the same cycle.
          if (ks_valid) begin
            rsp_data <= ks_data;
`ifdef CHACHA_ARB_WDOG_EN
            err_pend <= 1'b0;
`endif
            state    <= S_RESP;
          end
`ifdef CHACHA_ARB_WDOG_EN
          else if (wdog_cnt == WD_W'(WDOG_CYCLES - 1)) begin
            rsp_data <= '0;
            err_pend <= 1'b1;
            state    <= S_RESP;
          end else begin
            wdog_cnt <= wdog_cnt + 1'b1;
          end
`endif
        end
        S_RESP: begin
          rsp_valid <= 1'b1;
          rsp_id    <= cur_id;
          busy      <= 1'b0;
          state     <= S_IDLE;
`ifdef CHACHA_ARB_WDOG_EN
          rsp_err   <= err_pend;
          if (!err_pend) begin
            blk_count <= blk_count + 32'd1;
          end
`else
          blk_count <= blk_count + 32'd1;
`endif
        end
        default: begin
          busy  <= 1'b0;
          state <= S_IDLE;
        end
      endcase
    end
  end

`ifndef CHACHA_ARB_WDOG_EN
  assign rsp_err = 1'b0;
`endif

endmodule
